// File: rtl/regfile_mp.sv
// =============================================================================
// regfile_mp : multi-read-port integer register file with post-reset clear
// sequencer; optional write trace port under macro REGFILE_TRACE_EN.  Rev 1.0
// =============================================================================
`default_nettype none

module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  input  logic                rd_we,
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     rd_data
`ifdef REGFILE_TRACE_EN
  ,
  output logic                trace_valid,
  output logic [AW-1:0]       trace_addr,
  output logic [XLEN-1:0]     trace_data
`endif
);

  localparam logic [0:0]    c_CLEAR = 1'b0;
  localparam logic [0:0]    c_READY = 1'b1;
  localparam logic [AW-1:0] c_LAST  = AW'(NREGS - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [AW-1:0]    r_clr_idx;
  logic             w_clr_we;
  logic             w_ready;
  logic             w_wr_acc;
  logic [XLEN-1:0]  r_mem [NREGS];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_CLEAR;
      r_clr_idx <= AW'(1);
    end else begin
      r_state <= w_state_nxt;
      if (w_clr_we) begin
        r_clr_idx <= r_clr_idx + AW'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == c_CLEAR && r_clr_idx == c_LAST) begin
      w_state_nxt = c_READY;
    end
  end

  // Output decode
  always_comb begin
    w_clr_we = (r_state == c_CLEAR);
    w_ready  = (r_state == c_READY);
  end

  assign ready    = w_ready;
  assign w_wr_acc = rd_we & w_ready & rst_n;

  // Storage is not reset; the clear sequencer zeroes it before ready rises.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_clr_we) begin
        r_mem[r_clr_idx] <= '0;
      end else if (w_wr_acc && rd_addr != '0) begin
        r_mem[rd_addr] <= rd_data;
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_byp;
    assign w_addr = rs_addr[gi*AW +: AW];
    assign w_byp  = (BYPASS != 0) && w_wr_acc && (rd_addr == w_addr);
    assign rs_data[gi*XLEN +: XLEN] = (!w_ready || w_addr == '0) ? '0 :
                                      w_byp ? rd_data : r_mem[w_addr];
  end

`ifdef REGFILE_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trace_valid <= 1'b0;
      trace_addr  <= '0;
      trace_data  <= '0;
    end else if (w_wr_acc) begin
      trace_valid <= 1'b1;
      trace_addr  <= rd_addr;
      trace_data  <= (rd_addr == '0) ? '0 : rd_data;
    end else begin
      trace_valid <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire
